// File: rtl/inert_intf_seq.sv
// Inertial sensor sequencer: power-up init over the shared SPI master, then pitch-rate/Z-accel reads on data-ready.
// Define FAST_SIM_EN to shorten the power-up settle wait to the low 9 timer bits for simulation.
module inert_intf_seq #(
  parameter int INIT_CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  typedef enum logic [3:0] {
    INIT_WAIT = 4'd0,
    INIT1     = 4'd1,
    INIT2     = 4'd2,
    INIT3     = 4'd3,
    INIT4     = 4'd4,
    IDLE      = 4'd5,
    RD_PL     = 4'd6,
    RD_PH     = 4'd7,
    RD_AL     = 4'd8,
    RD_AH     = 4'd9
  } state_t;

  localparam logic [15:0] CMD_INT_EN = 16'h0D02;
  localparam logic [15:0] CMD_ACC    = 16'h1053;
  localparam logic [15:0] CMD_GYRO   = 16'h1150;
  localparam logic [15:0] CMD_ROUND  = 16'h1460;
  localparam logic [15:0] CMD_RD_PL  = 16'hA200;
  localparam logic [15:0] CMD_RD_PH  = 16'hA300;
  localparam logic [15:0] CMD_RD_AL  = 16'hAC00;
  localparam logic [15:0] CMD_RD_AH  = 16'hAD00;

  state_t                  state_r, state_s;
  logic [INIT_CNT_W-1:0]   timer_r, timer_s, timer_inc_s;
  logic                    init_go_s;
  logic                    wrt_r, wrt_s;
  logic [15:0]             cmd_r, cmd_s;
  logic                    vld_r, vld_s;
  logic [15:0]             ptch_r, ptch_s;
  logic [15:0]             az_r, az_s;
  logic [7:0]              pl_r, pl_s, ph_r, ph_s, al_r, al_s;
  logic                    int_ff1_r, int_ff2_r;
  logic                    accept_s;
  logic                    rd_hi_unused_s;

  assign timer_inc_s = timer_r + {{(INIT_CNT_W-1){1'b0}}, 1'b1};
`ifdef FAST_SIM_EN
  assign init_go_s = &timer_inc_s[8:0];
`else
  assign init_go_s = &timer_inc_s;
`endif

  // A done landing in the same cycle as wrt belongs to no transaction yet
  assign accept_s       = done & ~wrt_r;
  assign rd_hi_unused_s = ^rd_data[15:8];

  // Two-flop synchronizer for the asynchronous data-ready interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1_r <= 1'b0;
      int_ff2_r <= 1'b0;
    end else begin
      int_ff1_r <= INT;
      int_ff2_r <= int_ff1_r;
    end
  end

  // Next-state, command issue and sample assembly
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    wrt_s   = 1'b0;
    cmd_s   = cmd_r;
    vld_s   = 1'b0;
    ptch_s  = ptch_r;
    az_s    = az_r;
    pl_s    = pl_r;
    ph_s    = ph_r;
    al_s    = al_r;
    case (state_r)
      INIT_WAIT: begin
        timer_s = timer_inc_s;
        if (init_go_s) begin
          wrt_s = 1'b1; cmd_s = CMD_INT_EN; state_s = INIT1;
        end else begin
          state_s = INIT_WAIT;
        end
      end
      INIT1: begin
        if (accept_s) begin
          wrt_s = 1'b1; cmd_s = CMD_ACC; state_s = INIT2;
        end else begin
          state_s = INIT1;
        end
      end
      INIT2: begin
        if (accept_s) begin
          wrt_s = 1'b1; cmd_s = CMD_GYRO; state_s = INIT3;
        end else begin
          state_s = INIT2;
        end
      end
      INIT3: begin
        if (accept_s) begin
          wrt_s = 1'b1; cmd_s = CMD_ROUND; state_s = INIT4;
        end else begin
          state_s = INIT3;
        end
      end
      INIT4: begin
        if (accept_s) begin
          state_s = IDLE;
        end else begin
          state_s = INIT4;
        end
      end
      IDLE: begin
        // Level sensitive: INT still high after a read starts the next one
        if (int_ff2_r) begin
          wrt_s = 1'b1; cmd_s = CMD_RD_PL; state_s = RD_PL;
        end else begin
          state_s = IDLE;
        end
      end
      RD_PL: begin
        if (accept_s) begin
          pl_s = rd_data[7:0]; wrt_s = 1'b1; cmd_s = CMD_RD_PH; state_s = RD_PH;
        end else begin
          state_s = RD_PL;
        end
      end
      RD_PH: begin
        if (accept_s) begin
          ph_s = rd_data[7:0]; wrt_s = 1'b1; cmd_s = CMD_RD_AL; state_s = RD_AL;
        end else begin
          state_s = RD_PH;
        end
      end
      RD_AL: begin
        if (accept_s) begin
          al_s = rd_data[7:0]; wrt_s = 1'b1; cmd_s = CMD_RD_AH; state_s = RD_AH;
        end else begin
          state_s = RD_AL;
        end
      end
      RD_AH: begin
        if (accept_s) begin
          ptch_s  = {ph_r, pl_r};
          az_s    = {rd_data[7:0], al_r};
          vld_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = RD_AH;
        end
      end
      default: begin
        state_s = INIT_WAIT;
        timer_s = {INIT_CNT_W{1'b0}};
      end
    endcase
  end

  // State, timer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= INIT_WAIT;
      timer_r <= {INIT_CNT_W{1'b0}};
      wrt_r   <= 1'b0;
      cmd_r   <= 16'h0000;
      vld_r   <= 1'b0;
      ptch_r  <= 16'h0000;
      az_r    <= 16'h0000;
      pl_r    <= 8'h00;
      ph_r    <= 8'h00;
      al_r    <= 8'h00;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      wrt_r   <= wrt_s;
      cmd_r   <= cmd_s;
      vld_r   <= vld_s;
      ptch_r  <= ptch_s;
      az_r    <= az_s;
      pl_r    <= pl_s;
      ph_r    <= ph_s;
      al_r    <= al_s;
    end
  end

  assign wrt     = wrt_r;
  assign cmd     = cmd_r;
  assign vld     = vld_r;
  assign ptch_rt = ptch_r;
  assign AZ      = az_r;

endmodule

// File: tb/tb_inert_intf_seq.sv
// Randomized bench for inert_intf_seq: SPI responder plus a transaction-level model of the command
// list and sample assembly, compared against the DUT every cycle.
module tb_inert_intf_seq;
  localparam int INIT_CNT_W = 16;
`ifdef FAST_SIM_EN
  localparam int WAIT = 511;
`else
  localparam int WAIT = (1 << INIT_CNT_W) - 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n, INT, done;
  logic [15:0] rd_data;
  logic        wrt, vld;
  logic [15:0] cmd, ptch_rt, AZ;

  inert_intf_seq #(.INIT_CNT_W(INIT_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Model: position in the command list 0D02,1053,1150,1460,A200,A300,AC00,AD00
  bit          m_wait, m_idle, m_pending, v1, v2, spur;
  int          m_idx, cyc, countdown, first_wrt_cyc;
  logic [15:0] m_cmd, m_ptch, m_az;
  logic [7:0]  m_bytes [4];
  logic [7:0]  rd_q [$];
  int          wrt_cnt = 0, vld_cnt = 0, rd_dones = 0;

  function automatic logic [15:0] cmd_of(int i);
    case (i)
      0: return 16'h0D02;  1: return 16'h1053;  2: return 16'h1150;  3: return 16'h1460;
      4: return 16'hA200;  5: return 16'hA300;  6: return 16'hAC00;  7: return 16'hAD00;
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    m_wait = 1'b1; m_idle = 1'b0; m_pending = 1'b0; m_idx = 0; cyc = 0;
    m_cmd = 16'h0000; m_ptch = 16'h0000; m_az = 16'h0000; v1 = 1'b0; v2 = 1'b0;
  endtask

  // One clock: predict, compare, then drive the responder for the next edge
  task automatic step();
    bit exp_wrt, exp_vld, v0;
    @(posedge clk);
    #1;
    exp_wrt = 1'b0;
    exp_vld = 1'b0;
    if (!rst_n) begin
      mdl_reset();
    end else begin
      v0 = INT;
      cyc++;
      if (m_wait) begin
        if (cyc == WAIT) begin exp_wrt = 1'b1; m_idx = 0; m_wait = 1'b0; end
      end else if (m_idle) begin
        if (v2) begin exp_wrt = 1'b1; m_idx = 4; m_idle = 1'b0; end
      end else if (m_pending && done) begin
        m_pending = 1'b0;
        if (m_idx >= 4) m_bytes[m_idx-4] = rd_data[7:0];
        if (m_idx == 3) begin
          m_idle = 1'b1;
        end else if (m_idx == 7) begin
          m_idle  = 1'b1;
          exp_vld = 1'b1;
          m_ptch  = {m_bytes[1], m_bytes[0]};
          m_az    = {m_bytes[3], m_bytes[2]};
        end else begin
          exp_wrt = 1'b1;
          m_idx++;
        end
      end
      if (exp_wrt) begin m_cmd = cmd_of(m_idx); m_pending = 1'b1; end
      v2 = v1;
      v1 = v0;
    end
    chk("wrt", 32'(wrt), 32'(exp_wrt));
    chk("cmd", 32'(cmd), 32'(m_cmd));
    chk("vld", 32'(vld), 32'(exp_vld));
    chk("ptch_rt", 32'(ptch_rt), 32'(m_ptch));
    chk("AZ", 32'(AZ), 32'(m_az));
    if (wrt && wrt_cnt == 0) first_wrt_cyc = cyc;
    if (wrt) wrt_cnt++;
    if (vld) vld_cnt++;
    done    = 1'b0;
    rd_data = 16'($urandom);
    if (!rst_n) begin
      countdown = 0;
    end else if (wrt) begin
      countdown = 9;
    end else if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        done = 1'b1;
        if (cmd[15]) begin
          rd_dones++;
          if (rd_q.size() > 0) rd_data[7:0] = rd_q.pop_front();
        end
      end
    end else if (spur) begin
      done = 1'b1;
    end
    spur = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] b0, b1, b2, b3);
    int start;
    start = vld_cnt;
    rd_q.push_back(b0); rd_q.push_back(b1); rd_q.push_back(b2); rd_q.push_back(b3);
    INT = 1'b1;
    for (int i = 0; i < 10 && !wrt; i++) step();
    INT = 1'b0;
    for (int i = 0; i < 100 && vld_cnt == start; i++) step();
    chk("read_vld_seen", 32'(vld_cnt - start), 32'd1);
  endtask

  initial begin
    int start, n;
    rst_n = 1'b0; INT = 1'b0; done = 1'b0; rd_data = 16'h0000; spur = 1'b0; countdown = 0;
    first_wrt_cyc = -1;
    mdl_reset();
    repeat (3) step();
    chk("rst_wrt", 32'(wrt), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'h0000);
    chk("rst_vld", 32'(vld), 32'd0);
    rst_n = 1'b1;

    // Power-up init
    repeat (WAIT + 80) step();
    chk("first_wrt_cycle", 32'(first_wrt_cyc), 32'(WAIT));
    chk("init_wrt_count", 32'(wrt_cnt), 32'd4);
    chk("init_last_cmd", 32'(cmd), 32'h1460);

    // Spurious done in IDLE
    spur = 1'b1;
    repeat (20) step();
    chk("spur_wrt_count", 32'(wrt_cnt), 32'd4);
    chk("spur_vld_count", 32'(vld_cnt), 32'd0);

    do_read(8'h34, 8'h12, 8'h78, 8'h56);
    chk("rd1_ptch", 32'(ptch_rt), 32'h1234);
    chk("rd1_az", 32'(AZ), 32'h5678);

    do_read(8'hF0, 8'hFF, 8'h00, 8'h02);
    chk("rd2_ptch", 32'(ptch_rt), 32'hFFF0);
    chk("rd2_az", 32'(AZ), 32'h0200);

    // Outputs must hold while the next read is in flight
    INT = 1'b1;
    repeat (3) step();
    INT = 1'b0;
    repeat (20) step();
    chk("hold_ptch", 32'(ptch_rt), 32'hFFF0);
    chk("hold_az", 32'(AZ), 32'h0200);
    repeat (60) step();

    // INT held high: back-to-back reads
    start = vld_cnt;
    INT = 1'b1;
    for (int i = 0; i < 500 && vld_cnt < start + 3; i++) step();
    INT = 1'b0;
    repeat (120) step();
    chk("held_vld_min", 32'(vld_cnt >= start + 3), 32'd1);
    chk("vld_per_4_dones", 32'(rd_dones), 32'(4 * vld_cnt));

    // Random INT activity and stray dones
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) INT = ~INT;
      spur = !m_pending && ($urandom_range(0, 7) == 0);
      step();
    end
    INT = 1'b0;
    repeat (120) step();
    chk("rand_vld_per_4_dones", 32'(rd_dones), 32'(4 * vld_cnt));

    // Reset while in RD_AL
    INT = 1'b1;
    repeat (3) step();
    INT = 1'b0;
    for (int i = 0; i < 100 && !(m_pending && m_idx == 6); i++) step();
    repeat (3) step();
    chk("reached_rd_al", 32'(m_pending && m_idx == 6), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(vld), 32'd0);
    chk("mid_rst_wrt", 32'(wrt), 32'd0);
    chk("mid_rst_cmd", 32'(cmd), 32'h0000);
    chk("mid_rst_ptch", 32'(ptch_rt), 32'h0000);
    chk("mid_rst_az", 32'(AZ), 32'h0000);
    repeat (2) step();
    rst_n = 1'b1;
    start = wrt_cnt;
    n = (WAIT < 1500) ? WAIT + 60 : 1500;
    repeat (n) step();
    chk("restart_wrts", 32'(wrt_cnt - start), (WAIT < 1500) ? 32'd4 : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
